// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared widths, limits and mode sequencing for clock_ctrl
// The SET_AH/SET_AM states exist only when CLOCK_ALARM_EN is defined.
package clock_pkg;

   localparam int HOUR_W     = 5;
   localparam int MIN_W      = 6;
   localparam logic [MIN_W-1:0] SEC_MAX = 6'd59;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
   localparam int RING_TICKS = 60;

`ifdef CLOCK_ALARM_EN
   typedef enum logic [2:0] {
      RUN    = 3'd0,
      SET_H  = 3'd1,
      SET_M  = 3'd2,
      SET_AH = 3'd3,
      SET_AM = 3'd4
   } state_e;
`else
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2
   } state_e;
`endif

   function automatic state_e next_state(state_e s);
      case (s)
         RUN:    return SET_H;
         SET_H:  return SET_M;
`ifdef CLOCK_ALARM_EN
         SET_M:  return SET_AH;
         SET_AH: return SET_AM;
`endif
         default: return RUN;
      endcase
   endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// rtl/clock_ctrl_if.sv - tick/button inputs and display outputs of clock_ctrl
interface clock_ctrl_if;

   logic       tick_1hz;
   logic       btn_mode;
   logic       btn_inc;
   logic [4:0] hour;
   logic [5:0] minute;
   logic [5:0] second;
   logic [1:0] mode;
   logic       blink;
   logic       chime;
   logic       alarm_ring;

   modport master (
      output tick_1hz, btn_mode, btn_inc,
      input  hour, minute, second, mode, blink, chime, alarm_ring
   );

   modport slave (
      input  tick_1hz, btn_mode, btn_inc,
      output hour, minute, second, mode, blink, chime, alarm_ring
   );

endinterface

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - registered rising-edge detector for a debounced button level
module btn_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   logic btn_q, btn_d;
   logic armed_q, armed_d;

   // armed_q masks the first sampled cycle so a level held through reset is not a press
   always_comb begin
      btn_d   = btn;
      armed_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         btn_q   <= btn_d;
         armed_q <= armed_d;
      end
   end

   assign press = btn & ~btn_q & armed_q;

endmodule

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - hh:mm:ss time keeper with run/set sequencing, blink and hourly chime
// Defining CLOCK_ALARM_EN adds alarm_h/alarm_m, the SET_AH/SET_AM states and alarm_ring.
module clock_ctrl
   import clock_pkg::*;
#(
   parameter int HOUR_MOD = 24
) (
   input  logic        clk_100Mhz,
   input  logic        rst_n,
   clock_ctrl_if.slave bus
);

   localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MOD - 1);

   logic mode_press, inc_press;

   btn_edge u_mode_edge (.clk(clk_100Mhz), .rst_n(rst_n), .btn(bus.btn_mode), .press(mode_press));
   btn_edge u_inc_edge  (.clk(clk_100Mhz), .rst_n(rst_n), .btn(bus.btn_inc),  .press(inc_press));

   state_e            state_q, state_d;
   logic [HOUR_W-1:0] hour_q, hour_d;
   logic [MIN_W-1:0]  minute_q, minute_d;
   logic [MIN_W-1:0]  second_q, second_d;
   logic              blink_q, blink_d;
   logic              chime_q, chime_d;

   always_comb begin
      state_d  = state_q;
      hour_d   = hour_q;
      minute_d = minute_q;
      second_d = second_q;
      blink_d  = blink_q;
      chime_d  = 1'b0;

      if (mode_press) state_d = next_state(state_q);

      // A RUN tick is applied even when a mode press leaves RUN in the same cycle
      if (state_q == RUN && bus.tick_1hz) begin
         second_d = (second_q == SEC_MAX) ? '0 : second_q + 1'b1;
         if (second_q == SEC_MAX) begin
            minute_d = (minute_q == MIN_MAX) ? '0 : minute_q + 1'b1;
            if (minute_q == MIN_MAX) begin
               hour_d  = (hour_q == HOUR_LAST) ? '0 : hour_q + 1'b1;
               chime_d = 1'b1;
            end
         end
      end

      if (inc_press && !mode_press) begin
         case (state_q)
            SET_H:   hour_d   = (hour_q == HOUR_LAST) ? '0 : hour_q + 1'b1;
            SET_M:   minute_d = (minute_q == MIN_MAX) ? '0 : minute_q + 1'b1;
            default: ;
         endcase
      end

      if (state_q != RUN && state_d == RUN) second_d = '0;

      if (state_d == RUN)                          blink_d = 1'b0;
      else if (state_q != RUN && bus.tick_1hz)    blink_d = ~blink_q;
   end

   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         hour_q   <= '0;
         minute_q <= '0;
         second_q <= '0;
         blink_q  <= 1'b0;
         chime_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hour_q   <= hour_d;
         minute_q <= minute_d;
         second_q <= second_d;
         blink_q  <= blink_d;
         chime_q  <= chime_d;
      end
   end

`ifdef CLOCK_ALARM_EN
   localparam logic [5:0] RING_LAST = 6'(RING_TICKS - 1);

   logic [HOUR_W-1:0] alarm_h_q, alarm_h_d;
   logic [MIN_W-1:0]  alarm_m_q, alarm_m_d;
   logic              ring_q, ring_d;
   logic [5:0]        ring_cnt_q, ring_cnt_d;

   always_comb begin
      alarm_h_d  = alarm_h_q;
      alarm_m_d  = alarm_m_q;
      ring_d     = ring_q;
      ring_cnt_d = ring_cnt_q;

      if (inc_press && !mode_press && state_q == SET_AH)
         alarm_h_d = (alarm_h_q == HOUR_LAST) ? '0 : alarm_h_q + 1'b1;
      if (inc_press && !mode_press && state_q == SET_AM)
         alarm_m_d = (alarm_m_q == MIN_MAX) ? '0 : alarm_m_q + 1'b1;

      if (state_q == RUN && bus.tick_1hz) begin
         if (hour_d == alarm_h_q && minute_d == alarm_m_q && second_d == '0) begin
            ring_d     = 1'b1;
            ring_cnt_d = '0;
         end else if (ring_q) begin
            if (ring_cnt_q == RING_LAST) ring_d = 1'b0;
            else                         ring_cnt_d = ring_cnt_q + 1'b1;
         end
      end

      if (inc_press || state_d != RUN) ring_d = 1'b0;
   end

   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         alarm_h_q  <= '0;
         alarm_m_q  <= '0;
         ring_q     <= 1'b0;
         ring_cnt_q <= '0;
      end else begin
         alarm_h_q  <= alarm_h_d;
         alarm_m_q  <= alarm_m_d;
         ring_q     <= ring_d;
         ring_cnt_q <= ring_cnt_d;
      end
   end

   assign bus.alarm_ring = ring_q;
`else
   assign bus.alarm_ring = 1'b0;
`endif

   assign bus.hour   = hour_q;
   assign bus.minute = minute_q;
   assign bus.second = second_q;
   assign bus.mode   = state_q[1:0];
   assign bus.blink  = blink_q;
   assign bus.chime  = chime_q;

endmodule
